// File: rtl/sj_arb_pkg.sv
// sj_arb_pkg: shared state encoding, width helper and default sizes for method-port arbiters
package sj_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;
  localparam int N_DEF          = 4;
  localparam int ARGW_DEF       = 64;
  localparam int RETW_DEF       = 32;
  localparam int HI_TIMEOUT_DEF = 15;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/sj_rr_pick.sv
// sj_rr_pick: combinational round-robin picker, first set request after ptr (mod N)
module sj_rr_pick
  import sj_arb_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);
  int j;
  always_comb begin
    valid = |req;
    idx   = '0;
    j     = 0;
    // Walk from farthest to nearest so the nearest set bit after ptr wins.
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) idx = IW'(j);
    end
  end
endmodule

// File: rtl/sj_method_arbiter.sv
// sj_method_arbiter: round-robin sharing of one req/busy/return method port among N callers
module sj_method_arbiter
  import sj_arb_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int ARGW       = ARGW_DEF,
  parameter int RETW       = RETW_DEF,
  parameter int HI_TIMEOUT = HI_TIMEOUT_DEF,
  localparam int IW = clog2(N),
  localparam int TW = clog2(HI_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      rq_req,
  input  logic [N*ARGW-1:0] rq_args,
  output logic [N-1:0]      rq_busy,
  output logic [N-1:0]      rq_done,
  output logic [RETW-1:0]   rq_return,
  output logic [IW-1:0]     grant_id,
  output logic [ARGW-1:0]   m_args,
  output logic              m_req,
  input  logic              m_busy,
  input  logic [RETW-1:0]   m_return,
  output logic              err_timeout
);
  state_t          state;
  logic [IW-1:0]   ptr;
  logic [TW-1:0]   cnt;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [ARGW-1:0] args_arr [N];
  for (genvar i = 0; i < N; i++) begin : g_args
    assign args_arr[i] = rq_args[i*ARGW +: ARGW];
  end
  sj_rr_pick #(.N(N)) u_pick (
    .req   (rq_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IW'(N - 1);
      cnt         <= '0;
      rq_busy     <= '0;
      rq_done     <= '0;
      rq_return   <= '0;
      grant_id    <= '0;
      m_args      <= '0;
      m_req       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          grant_id <= pick_idx;
          ptr      <= pick_idx;
          m_args   <= args_arr[pick_idx];
          m_req    <= 1'b1;
          rq_busy  <= N'(1) << pick_idx;
          state    <= ISSUE;
        end
        ISSUE: begin
          m_req <= 1'b0;
          cnt   <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: if (m_busy) begin
          state <= WAIT_LO;
        end else if (cnt == TW'(HI_TIMEOUT - 1)) begin
          // Abandon the call but still complete the caller's handshake.
          err_timeout <= 1'b1;
          rq_return   <= m_return;
          rq_done     <= rq_busy;
          rq_busy     <= '0;
          state       <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        WAIT_LO: if (!m_busy) begin
          rq_return <= m_return;
          rq_done   <= rq_busy;
          rq_busy   <= '0;
          state     <= DONE;
        end
        DONE: begin
          rq_done <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sj_method_arbiter.sv
// tb_sj_method_arbiter: randomized scenario bench with a call-level round-robin reference model
module tb_sj_method_arbiter;
  localparam int N = 4, ARGW = 64, RETW = 32, IW = 2;
  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      rq_req;
  logic [N*ARGW-1:0] rq_args;
  logic [N-1:0]      rq_busy, rq_done;
  logic [RETW-1:0]   rq_return;
  logic [IW-1:0]     grant_id;
  logic [ARGW-1:0]   m_args;
  logic              m_req;
  logic              m_busy;
  logic [RETW-1:0]   m_return;
  logic              err_timeout;
  logic              dead;
  int                left;
  int                tests = 0, fails = 0, overlap = 0, mreq_cnt = 0, done_cnt = 0;
  int                mptr;
  logic [31:0]       xs [N];
  logic [31:0]       ys [N];

  always #5 clk = ~clk;

  sj_method_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .rq_req      (rq_req),
    .rq_args     (rq_args),
    .rq_busy     (rq_busy),
    .rq_done     (rq_done),
    .rq_return   (rq_return),
    .grant_id    (grant_id),
    .m_args      (m_args),
    .m_req       (m_req),
    .m_busy      (m_busy),
    .m_return    (m_return),
    .err_timeout (err_timeout)
  );

  // Method model: busy one cycle after m_req, held 3 cycles, returns x+y.
  assign m_return = m_args[31:0] + m_args[63:32];
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      left   <= 0;
    end else if (m_req && !dead) begin
      m_busy <= 1'b1;
      left   <= 3;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 1) m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if ($countones(rq_busy) > 1 || $countones(rq_done) > 1) overlap++;
    if (m_req) mreq_cnt++;
    if (rq_done != 0) done_cnt++;
  end

  function automatic int rr_next(input logic [N-1:0] mask, input int p);
    for (int k = 1; k <= N; k++) if (mask[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_args(input int i, input logic [31:0] x, input logic [31:0] y);
    xs[i] = x;
    ys[i] = y;
    rq_args[i*ARGW +: ARGW] = {y, x};
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    rq_req  = '0;
    rq_args = '0;
    dead    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mptr  = N - 1;
  endtask

  // Waits for a done pulse; cyc counts negedges since the call, mc is the first m_req negedge.
  task automatic wait_done(output int idx, output int cyc, output int mc);
    idx = -1;
    cyc = 0;
    mc  = -1;
    do begin
      @(negedge clk);
      cyc++;
      if (m_req && mc < 0) mc = cyc;
    end while (cyc < 60 && rq_done == 0);
    for (int k = 0; k < N; k++) if (rq_done[k]) idx = k;
  endtask

  task automatic test_reset;
    do_reset;
    tests++; if (rq_busy !== 0) begin fails++; $display("FAIL reset_busy: got %b expected 0", rq_busy); end
    tests++; if (rq_done !== 0) begin fails++; $display("FAIL reset_done: got %b expected 0", rq_done); end
    tests++; if (rq_return !== 0) begin fails++; $display("FAIL reset_return: got %0d expected 0", rq_return); end
    tests++; if (grant_id !== 0) begin fails++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    tests++; if (m_args !== 0 || m_req !== 0) begin fails++; $display("FAIL reset_method: args %0h req %b expected 0", m_args, m_req); end
    tests++; if (err_timeout !== 0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
  endtask

  task automatic test_single;
    int idx, cyc, mc;
    do_reset;
    set_args(0, 3, 4);
    rq_req = 4'b0001;
    wait_done(idx, cyc, mc);
    if (idx >= 0) rq_req[idx] = 1'b0;
    tests++; if (mc !== 1) begin fails++; $display("FAIL single_mreq_latency: got %0d expected 1", mc); end
    tests++; if (cyc !== 6) begin fails++; $display("FAIL single_done_latency: got %0d expected 6", cyc); end
    tests++; if (idx !== 0) begin fails++; $display("FAIL single_done_idx: got %0d expected 0", idx); end
    tests++; if (rq_return !== 32'd7) begin fails++; $display("FAIL single_return: got %0d expected 7", rq_return); end
    tests++; if (m_args !== {32'd4, 32'd3}) begin fails++; $display("FAIL single_margs: got %0h expected %0h", m_args, {32'd4, 32'd3}); end
    @(negedge clk);
    tests++; if (rq_done !== 0) begin fails++; $display("FAIL single_done_pulse: got %b expected 0", rq_done); end
  endtask

  task automatic test_all4;
    int idx, cyc, mc, exp, ov0;
    do_reset;
    for (int i = 0; i < N; i++) set_args(i, i, i);
    rq_req = '1;
    ov0 = overlap;
    for (int c = 0; c < N; c++) begin
      exp = rr_next(rq_req, mptr);
      wait_done(idx, cyc, mc);
      if (idx >= 0) rq_req[idx] = 1'b0;
      mptr = exp;
      tests++; if (idx !== exp) begin fails++; $display("FAIL all4_order%0d: got %0d expected %0d", c, idx, exp); end
      tests++; if (rq_return !== 32'(2 * exp)) begin fails++; $display("FAIL all4_return%0d: got %0d expected %0d", c, rq_return, 2 * exp); end
    end
    tests++; if (overlap !== ov0) begin fails++; $display("FAIL all4_overlap: got %0d expected %0d", overlap, ov0); end
  endtask

  task automatic test_fair;
    int idx, cyc, mc, exp;
    do_reset;
    set_args(0, 5, 6);
    set_args(2, 10, 20);
    rq_req = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      exp = rr_next(4'b0101, mptr);
      wait_done(idx, cyc, mc);
      if (c == 5) rq_req = '0;
      mptr = exp;
      tests++; if (idx !== exp) begin fails++; $display("FAIL fair_order%0d: got %0d expected %0d", c, idx, exp); end
      tests++; if (rq_return !== xs[exp] + ys[exp]) begin fails++; $display("FAIL fair_return%0d: got %0d expected %0d", c, rq_return, xs[exp] + ys[exp]); end
    end
  endtask

  task automatic test_timeout;
    int idx, cyc, mc;
    do_reset;
    dead = 1'b1;
    set_args(2, 1, 1);
    rq_req = 4'b0100;
    wait_done(idx, cyc, mc);
    if (idx >= 0) rq_req[idx] = 1'b0;
    tests++; if (idx !== 2) begin fails++; $display("FAIL timeout_idx: got %0d expected 2", idx); end
    tests++; if (cyc !== 17) begin fails++; $display("FAIL timeout_latency: got %0d expected 17", cyc); end
    tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b expected 1", err_timeout); end
    tests++; if (rq_return !== 32'd2) begin fails++; $display("FAIL timeout_return: got %0d expected 2", rq_return); end
    dead = 1'b0;
    set_args(1, 8, 9);
    rq_req = 4'b0010;
    wait_done(idx, cyc, mc);
    if (idx >= 0) rq_req[idx] = 1'b0;
    tests++; if (idx !== 1 || rq_return !== 32'd17) begin fails++; $display("FAIL timeout_next: idx %0d ret %0d expected 1 17", idx, rq_return); end
    tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout); end
  endtask

  task automatic test_reset_mid;
    int idx, cyc, mc, d0, exp;
    do_reset;
    set_args(1, 2, 2);
    rq_req = 4'b0010;
    repeat (3) @(negedge clk);
    tests++; if (rq_busy !== 4'b0010 || m_busy !== 1'b1) begin fails++; $display("FAIL rmid_inflight: busy %b m_busy %b expected 0010 1", rq_busy, m_busy); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if ({rq_busy, rq_done, m_req, err_timeout} !== 0 || rq_return !== 0 || m_args !== 0 || grant_id !== 0) begin
      fails++; $display("FAIL rmid_outputs: busy %b done %b mreq %b args %0h expected all 0", rq_busy, rq_done, m_req, m_args);
    end
    reset  = 1'b0;
    rq_req = '0;
    mptr   = N - 1;
    d0     = done_cnt;
    repeat (8) @(negedge clk);
    tests++; if (done_cnt !== d0) begin fails++; $display("FAIL rmid_no_done: got %0d expected %0d", done_cnt, d0); end
    set_args(2, 1, 2);
    rq_req = 4'b0110;
    exp = rr_next(rq_req, mptr);
    wait_done(idx, cyc, mc);
    rq_req = '0;
    tests++; if (idx !== exp) begin fails++; $display("FAIL rmid_ptr: got %0d expected %0d", idx, exp); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_drop;
    int idx, cyc, mc, m0;
    do_reset;
    set_args(1, 100, 23);
    m0 = mreq_cnt;
    rq_req = 4'b0010;
    @(negedge clk);
    rq_req = '0;
    wait_done(idx, cyc, mc);
    tests++; if (idx !== 1) begin fails++; $display("FAIL drop_idx: got %0d expected 1", idx); end
    tests++; if (rq_return !== 32'd123) begin fails++; $display("FAIL drop_return: got %0d expected 123", rq_return); end
    repeat (8) @(negedge clk);
    tests++; if (mreq_cnt !== m0 + 1) begin fails++; $display("FAIL drop_no_recall: got %0d expected %0d", mreq_cnt - m0, 1); end
  endtask

  task automatic test_random;
    int idx, cyc, mc, exp, n;
    logic [N-1:0] mask;
    do_reset;
    for (int r = 0; r < 12; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_args(i, $urandom, $urandom);
      rq_req = mask;
      n = $countones(mask);
      for (int c = 0; c < n; c++) begin
        exp = rr_next(rq_req, mptr);
        wait_done(idx, cyc, mc);
        if (idx >= 0) rq_req[idx] = 1'b0;
        mptr = exp;
        tests++; if (idx !== exp) begin fails++; $display("FAIL rand%0d_order%0d: got %0d expected %0d", r, c, idx, exp); end
        tests++; if (rq_return !== xs[exp] + ys[exp]) begin fails++; $display("FAIL rand%0d_return%0d: got %0h expected %0h", r, c, rq_return, xs[exp] + ys[exp]); end
      end
      rq_req = '0;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_all4;
    test_fair;
    test_timeout;
    test_reset_mid;
    test_drop;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
